// File: rtl/immed_gen_pkg.sv
// -----------------------------------------------------------------------------
// immed_gen_pkg
// Shared types and helpers for the OTTER immediate-generator pipeline:
//   imm_fmt_t    - immediate format tag carried with every result
//   pipe_state_t - occupancy state of the 2-entry skid buffer
//   imm_dec_t    - {format, 32-bit sign-extended immediate}
//   imm_decode() - opcode decode and RV32I immediate field assembly
// -----------------------------------------------------------------------------
package immed_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        imm_fmt_t    fmt;
        logic [31:0] imm;
    } imm_dec_t;

    // Selects the one immediate that the opcode implies and sign-extends it
    // from instr[31] to 32 bits. Unknown opcodes yield FMT_NONE with zero.
    function automatic imm_dec_t imm_decode(input logic [31:0] instr);
        imm_dec_t r;
        r.fmt = FMT_NONE;
        r.imm = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                r.fmt = FMT_I;
                r.imm = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                r.fmt = FMT_S;
                r.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                r.fmt = FMT_B;
                r.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                r.fmt = FMT_U;
                r.imm = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                r.fmt = FMT_J;
                r.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            end
            default: begin
                r.fmt = FMT_NONE;
                r.imm = '0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/immed_gen_pipe_skid.sv
// -----------------------------------------------------------------------------
// immed_skid_buf
// Generic 2-entry valid/ready skid buffer. The main register drives the
// output; the skid register catches the one extra word that can arrive in
// the cycle the consumer stalls. in_ready_o comes from registered state only.
// Ports:
//   clk_i, rst_i (async, active-high)
//   in_valid_i / in_ready_o / in_data_i    - upstream handshake and payload
//   out_valid_o / out_ready_i / out_data_o - downstream handshake and payload
// Parameter: W - payload width.
// -----------------------------------------------------------------------------
module immed_skid_buf
    import immed_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    pipe_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_d  = in_data_i;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data_i;
                end else if (in_fire) begin
                    // Consumer stalled: park the new word behind the head.
                    state_d = FULL;
                    skid_d  = in_data_i;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule

// File: rtl/immed_gen_pipe.sv
// -----------------------------------------------------------------------------
// immed_gen_pipe
// Registered RISC-V immediate generator with valid/ready on both sides.
// Decode is combinational on the input side; the result is registered in a
// 2-entry skid buffer, giving exactly one cycle of latency and lossless
// back-pressure.
// Ports:
//   CLK, RST (async, active-high)
//   IN_VALID / IN_READY, INSTR, PC_IN   - instruction in
//   OUT_VALID / OUT_READY               - result handshake
//   IMMED, IMM_TYPE, PC_OUT             - sign-extended immediate, format, PC
//   BR_TARGET                           - PC + IMMED for B/J formats
// Optional feature macro: IMMGEN_BTARGET_EN adds BR_TARGET and its adder.
// Parameter: XLEN (32 or 64).
// -----------------------------------------------------------------------------
module immed_gen_pipe
    import immed_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INSTR,
    input  logic [XLEN-1:0] PC_IN,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] IMMED,
    output logic [2:0]      IMM_TYPE,
    output logic [XLEN-1:0] PC_OUT
`ifdef IMMGEN_BTARGET_EN
    ,
    output logic [XLEN-1:0] BR_TARGET
`endif
);

    imm_dec_t        dec;
    logic [XLEN-1:0] imm_ext;

    assign dec     = imm_decode(INSTR);
    // The 32-bit immediate is already sign-extended from INSTR[31]; widen it.
    assign imm_ext = XLEN'($signed(dec.imm));

`ifdef IMMGEN_BTARGET_EN
    localparam int PW = 3 + 3 * XLEN;
    logic [XLEN-1:0] bt_in;

    always_comb begin
        bt_in = '0;
        if (dec.fmt == FMT_B || dec.fmt == FMT_J) begin
            bt_in = PC_IN + imm_ext;
        end
    end
`else
    localparam int PW = 3 + 2 * XLEN;
`endif

    logic [PW-1:0] pay_in, pay_out;

`ifdef IMMGEN_BTARGET_EN
    assign pay_in = {dec.fmt, imm_ext, PC_IN, bt_in};
    assign {IMM_TYPE, IMMED, PC_OUT, BR_TARGET} = pay_out;
`else
    assign pay_in = {dec.fmt, imm_ext, PC_IN};
    assign {IMM_TYPE, IMMED, PC_OUT} = pay_out;
`endif

    immed_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk_i       (CLK),
        .rst_i       (RST),
        .in_valid_i  (IN_VALID),
        .in_ready_o  (IN_READY),
        .in_data_i   (pay_in),
        .out_valid_o (OUT_VALID),
        .out_ready_i (OUT_READY),
        .out_data_o  (pay_out)
    );

endmodule

// File: tb/tb_immed_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_immed_gen_pipe
// Directed, table-driven bench for immed_gen_pipe (XLEN=32 instance) plus a
// small XLEN=64 instance for sign-extension of wide immediates.
// Honours IMMGEN_BTARGET_EN for the BR_TARGET port.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_immed_gen_pipe;
    import immed_gen_pkg::*;

    logic        CLK;
    logic        RST;
    logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [31:0] INSTR, PC_IN, IMMED, PC_OUT;
    logic [2:0]  IMM_TYPE;
`ifdef IMMGEN_BTARGET_EN
    logic [31:0] BR_TARGET;
`endif

    logic        v64, rdy64_in, ov64, or64;
    logic [31:0] instr64;
    logic [63:0] pc64, imm64, pcout64;
    logic [2:0]  typ64;
`ifdef IMMGEN_BTARGET_EN
    logic [63:0] bt64;
`endif

    int nchk = 0;
    int nerr = 0;

    immed_gen_pipe #(.XLEN(32)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .PC_IN     (PC_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .IMMED     (IMMED),
        .IMM_TYPE  (IMM_TYPE),
        .PC_OUT    (PC_OUT)
`ifdef IMMGEN_BTARGET_EN
        ,
        .BR_TARGET (BR_TARGET)
`endif
    );

    immed_gen_pipe #(.XLEN(64)) u_dut64 (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (v64),
        .IN_READY  (rdy64_in),
        .INSTR     (instr64),
        .PC_IN     (pc64),
        .OUT_VALID (ov64),
        .OUT_READY (or64),
        .IMMED     (imm64),
        .IMM_TYPE  (typ64),
        .PC_OUT    (pcout64)
`ifdef IMMGEN_BTARGET_EN
        ,
        .BR_TARGET (bt64)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", nerr);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [31:0] bt;
    } vec_t;

    vec_t vec[10];
    logic [31:0] got[$];
    int nacc;
    logic acc;

    initial begin
        vec[0] = '{32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, FMT_I,    32'h0};
        vec[1] = '{32'h00112623, 32'h0000_0004, 32'h0000_000C, FMT_S,    32'h0};
        vec[2] = '{32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, FMT_B,    32'h0000_00FC};
        vec[3] = '{32'h12345137, 32'h0000_0108, 32'h1234_5000, FMT_U,    32'h0};
        vec[4] = '{32'h0080006F, 32'h0000_0200, 32'h0000_0008, FMT_J,    32'h0000_0208};
        vec[5] = '{32'h00000033, 32'h0000_0204, 32'h0000_0000, FMT_NONE, 32'h0};
        vec[6] = '{32'hFFFFF017, 32'h0000_0300, 32'hFFFF_F000, FMT_U,    32'h0};
        vec[7] = '{32'h00008067, 32'h0000_0304, 32'h0000_0000, FMT_I,    32'h0};
        vec[8] = '{32'h80002083, 32'h0000_0308, 32'hFFFF_F800, FMT_I,    32'h0};
        vec[9] = '{32'h00000863, 32'h0000_1000, 32'h0000_0010, FMT_B,    32'h0000_1010};

        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; INSTR = '0; PC_IN = '0;
        v64 = 1'b0; or64 = 1'b0; instr64 = '0; pc64 = '0;
        #1 RST = 1'b1;
        #2;
        chk("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("rst_immed",     {32'd0, IMMED},     64'd0);
        chk("rst_imm_type",  {61'd0, IMM_TYPE},  64'(FMT_NONE));
        chk("rst_pc_out",    {32'd0, PC_OUT},    64'd0);
`ifdef IMMGEN_BTARGET_EN
        chk("rst_br_target", {32'd0, BR_TARGET}, 64'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, IN_READY}, 64'd1);

        // Streaming, consumer always ready.
        OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1;
            INSTR    = vec[i].instr;
            PC_IN    = vec[i].pc;
            step();
            chk($sformatf("v%0d_valid", i),  {63'd0, OUT_VALID}, 64'd1);
            chk($sformatf("v%0d_immed", i),  {32'd0, IMMED},     {32'd0, vec[i].imm});
            chk($sformatf("v%0d_type", i),   {61'd0, IMM_TYPE},  {61'd0, vec[i].typ});
            chk($sformatf("v%0d_pc", i),     {32'd0, PC_OUT},    {32'd0, vec[i].pc});
`ifdef IMMGEN_BTARGET_EN
            chk($sformatf("v%0d_bt", i),     {32'd0, BR_TARGET}, {32'd0, vec[i].bt});
`endif
        end
        IN_VALID = 1'b0;
        step();
        chk("drain_empty", {63'd0, OUT_VALID}, 64'd0);

        // Back-pressure: three back-to-back offers against a stalled consumer.
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        INSTR     = 32'h00100093;
        chk("bp_ready0", {63'd0, IN_READY}, 64'd1);
        step();
        INSTR = 32'h00200093;
        chk("bp_ready1", {63'd0, IN_READY}, 64'd1);
        step();
        INSTR = 32'h00300093;
        chk("bp_ready_full", {63'd0, IN_READY}, 64'd0);
        step();
        chk("bp_hold_ready", {63'd0, IN_READY},  64'd0);
        chk("bp_hold_valid", {63'd0, OUT_VALID}, 64'd1);
        chk("bp_hold_immed", {32'd0, IMMED},     64'd1);
        OUT_READY = 1'b1;
        nacc = 2;
        for (int c = 0; c < 10; c++) begin
            acc = IN_VALID && IN_READY;
            if (OUT_VALID && OUT_READY) got.push_back(IMMED);
            step();
            if (acc) begin
                nacc++;
                IN_VALID = 1'b0;
            end
        end
        chk("bp_accepted", 64'(nacc), 64'd3);
        chk("bp_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            chk($sformatf("bp_order%0d", k), {32'd0, got[k]}, 64'(k + 1));
        end
        chk("bp_drained", {63'd0, OUT_VALID}, 64'd0);

        // Asynchronous reset while FULL.
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        INSTR     = 32'h00700093;
        step();
        INSTR = 32'h00800093;
        step();
        chk("ar_full", {63'd0, IN_READY}, 64'd0);
        #3 RST = 1'b1;
        #1;
        chk("ar_out_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("ar_immed",     {32'd0, IMMED},     64'd0);
        #1 RST = 1'b0;
        INSTR     = 32'h00500093;
        PC_IN     = 32'h0000_0040;
        OUT_READY = 1'b1;
        #1;
        chk("ar_in_ready", {63'd0, IN_READY}, 64'd1);
        step();
        IN_VALID = 1'b0;
        chk("ar_next_valid", {63'd0, OUT_VALID}, 64'd1);
        chk("ar_next_immed", {32'd0, IMMED},     64'd5);
        chk("ar_next_pc",    {32'd0, PC_OUT},    64'h40);
        step();
        chk("ar_alone", {63'd0, OUT_VALID}, 64'd0);

        // XLEN=64 sign extension.
        or64    = 1'b1;
        v64     = 1'b1;
        instr64 = 32'h80000137;
        pc64    = 64'h0000_0000_0000_0123;
        chk("x64_ready", {63'd0, rdy64_in}, 64'd1);
        step();
        chk("x64_lui_valid", {63'd0, ov64}, 64'd1);
        chk("x64_lui_immed", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("x64_lui_type",  {61'd0, typ64}, 64'(FMT_U));
        chk("x64_lui_pc",    pcout64, 64'h123);
`ifdef IMMGEN_BTARGET_EN
        chk("x64_lui_bt",    bt64, 64'd0);
`endif
        instr64 = 32'hFFF00093;
        step();
        chk("x64_addi_immed", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        instr64 = 32'h0080006F;
        pc64    = 64'h0000_0001_0000_1000;
        step();
        chk("x64_jal_immed", imm64, 64'h8);
        chk("x64_jal_type",  {61'd0, typ64}, 64'(FMT_J));
`ifdef IMMGEN_BTARGET_EN
        chk("x64_jal_bt",    bt64, 64'h0000_0001_0000_1008);
`endif
        v64 = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
